mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access sequencer for the MIPS pipeline: consumes the load/store control strobes produced by instruction decode, the ALU-computed effective address and the store data, and runs one request/acknowledge transaction per access on a word-wide memory bus. Handles byte/half/word lane steering, load sign/zero extension, misalignment detection and pipeline stall generation. Sits between the execute/memory stage and the data memory or cache.

## Interface
- ADDR_W, 32, byte-address width on both pipeline and memory sides.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- re_in  in  1  load request from decode, held while the instruction is stalled in this stage.
- we_in  in  1  store request from decode, same holding rule.
- size_in  in  2  access size: SZ_WORD=00, SZ_HALF=01, SZ_BYTE=10; 11 is illegal.
- unsigned_in  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- addr_in  in  ADDR_W  effective byte address.
- wdata_in  in  32  store data, right-justified.
- stall  out  1  freezes upstream stages while high.
- rdata_out  out  32  extended load result, valid with rdata_valid, held otherwise.
- rdata_valid  out  1  one-cycle pulse on load completion.
- misalign_err  out  1  one-cycle pulse for a rejected access.
- mem_req  out  1  bus request, held until mem_ack.
- mem_we  out  1  1 = write transaction.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion; read data valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: a request is re_in or we_in. It is legal when exactly one strobe is high, size_in != 11, half has addr_in[0]=0, and word has addr_in[1:0]=00.
- Legal request in IDLE: latch addr/size/unsigned/lane data, drive the bus registers, go to WAIT.
- Illegal request in IDLE (misaligned, size 11, or both strobes high): no bus access, misalign_err pulses the next cycle, stay in IDLE.
- WAIT: mem_req=1 and all mem_* outputs stay stable. mem_ack=1 leads to DONE; mem_req drops on that edge, and for loads the extended word is registered into rdata_out.
- DONE: lasts exactly one cycle. rdata_valid=1 for loads only, stall=0. re_in and we_in are ignored because they still belong to the completing instruction. Next state is IDLE.
- mem_ack outside WAIT is ignored.
- Store lanes:
  - Byte: mem_be = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_be = 1111.
- Loads drive the same mem_be pattern with mem_we=0.
- Load extract:
  - Byte: mem_rdata[8*addr[1:0] +: 8].
  - Half: mem_rdata[16*addr[1] +: 16].
  - Extend to 32 bits per unsigned_in.

## Timing
- Reset (async): state IDLE. mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata_out, rdata_valid and misalign_err are all 0. stall is forced 0 while rst_n=0.
- stall is combinational: 1 in WAIT, and 1 in IDLE when a legal request is present. It is 0 in DONE, 0 for an illegal request, and 0 otherwise.
- Latency: request seen in IDLE at cycle T, mem_req from T+1, ack at T+1+k (k ≥ 0 wait cycles), DONE at T+2+k. Minimum is 3 cycles per access.
- Back-to-back: a new request is accepted in the cycle after DONE.
- Reset in WAIT: mem_req drops immediately, the transaction is abandoned, and a late ack is ignored.
- rdata_out changes only on a load ack.

## Structure
- Package mips_mem_pkg: size encodings SZ_WORD/SZ_HALF/SZ_BYTE, the state enum, and BE_ALL=4'b1111.
- One combinational sub-module, mem_lane_steer: store replication plus byte-enable generation, and load extraction plus extension. The sequencer instantiates it once.

## Test plan
- Zero-wait load word, addr 0x100, mem_rdata 0xDEADBEEF, ack with req: mem_addr 0x100, be 1111; rdata_out 0xDEADBEEF with rdata_valid at T+2; stall high in T and T+1 only.
- lb signed, addr 0x203, rdata 0x80FF_0000 → be 1000, rdata_out 0xFFFFFF80. Same access with lbu → 0x00000080.
- sh, addr 0x302, wdata 0x0000ABCD, 3 wait cycles: mem_wdata 0xABCDABCD, be 1100, mem_we=1, all outputs stable for 4 cycles, no rdata_valid.
- lw at 0x101 or lh at 0x103: no mem_req, misalign_err pulse at T+1, stall 0. Both strobes high behaves the same.
- re_in held high through DONE: exactly one transaction issued; a second load presented the cycle after DONE is accepted.
- rst_n low during WAIT: mem_req 0 immediately. Ack after reset release: no rdata_valid, state IDLE.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module  : mips_mem_pkg
// Purpose : Shared encodings and legality check for the data-memory access unit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Exactly one strobe, a defined size and natural alignment.
  function automatic logic access_legal(input logic re, input logic we,
                                        input size_e sz, input logic [1:0] addr_lo);
    logic ok;
    ok = re ^ we;
    case (sz)
      SZ_WORD: ok = ok && (addr_lo == 2'b00);
      SZ_HALF: ok = ok && !addr_lo[0];
      SZ_BYTE: ok = ok;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module  : mem_access_unit_if
// Purpose : Word-wide request/acknowledge data-memory bus
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit_lane_steer.sv
// ============================================================================
// Module  : mem_lane_steer
// Purpose : Store lane replication / byte enables and load extraction / extension
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_steer
  import mips_mem_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  size_e       ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  always_comb begin
    st_be        = 4'b0000;
    st_wdata_rep = st_wdata;
    case (st_size)
      SZ_WORD: st_be = BE_ALL;
      SZ_HALF: begin
        st_be        = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      SZ_BYTE: begin
        st_be        = 4'b0001 << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      default: st_be = 4'b0000;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_rdata[8*ld_addr_lo +: 8];
    ld_half = ld_rdata[16*ld_addr_lo[1] +: 16];
    ld_data = ld_rdata;
    case (ld_size)
      SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Purpose : Load/store sequencer driving one req/ack transaction per access
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_in,
  input  logic              we_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  output logic              stall,
  output logic [31:0]       rdata_out,
  output logic              rdata_valid,
  output logic              misalign_err,
  mem_access_unit_if.master bus
);

  state_e            state_q, state_d;
  logic              is_load_q, is_load_d;
  size_e             size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              misalign_q, misalign_d;
  logic              stall_c;

  size_e       size_in_e;
  logic        req_present;
  logic        req_legal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;

  assign size_in_e   = size_e'(size_in);
  assign req_present = re_in | we_in;
  assign req_legal   = access_legal(re_in, we_in, size_in_e, addr_in[1:0]);

  mem_lane_steer u_steer (
    .st_size      (size_in_e),
    .st_addr_lo   (addr_in[1:0]),
    .st_wdata     (wdata_in),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (size_q),
    .ld_addr_lo   (addr_lo_q),
    .ld_unsigned  (unsigned_q),
    .ld_rdata     (bus.mem_rdata),
    .ld_data      (ld_data)
  );

  always_comb begin
    state_d       = state_q;
    is_load_d     = is_load_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    addr_lo_d     = addr_lo_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    misalign_d    = 1'b0;
    stall_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_present && req_legal) begin
          state_d     = ST_WAIT;
          stall_c     = 1'b1;
          is_load_d   = re_in;
          size_d      = size_in_e;
          unsigned_d  = unsigned_in;
          addr_lo_d   = addr_in[1:0];
          mem_req_d   = 1'b1;
          mem_we_d    = we_in;
          mem_addr_d  = {addr_in[ADDR_W-1:2], 2'b00};
          mem_be_d    = st_be;
          mem_wdata_d = we_in ? st_wdata_rep : 32'h0;
        end else if (req_present) begin
          misalign_d = 1'b1;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (bus.mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (is_load_q) begin
            rdata_d       = ld_data;
            rdata_valid_d = 1'b1;
          end
        end
      end
      // Strobes seen here still belong to the completing instruction.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      is_load_q     <= 1'b0;
      size_q        <= SZ_WORD;
      unsigned_q    <= 1'b0;
      addr_lo_q     <= 2'b00;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= 4'b0000;
      mem_wdata_q   <= 32'h0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_load_q     <= is_load_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      addr_lo_q     <= addr_lo_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign stall         = stall_c & rst_n;
  assign rdata_out     = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign misalign_err  = misalign_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Directed plus randomized self-checking bench for mem_access_unit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re_in = 1'b0;
  logic        we_in = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic        unsigned_in = 1'b0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] wdata_in = 32'h0;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        misalign_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd = 32'h0;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .re_in        (re_in),
    .we_in        (we_in),
    .size_in      (size_in),
    .unsigned_in  (unsigned_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .stall        (stall),
    .rdata_out    (rdata_out),
    .rdata_valid  (rdata_valid),
    .misalign_err (misalign_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: access width in bytes, 0 for the undefined size code.
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_legal(input logic re, input logic we, input logic [1:0] sz,
                                   input logic [31:0] addr);
    int n;
    n = nbytes(sz);
    return (re != we) && (n != 0) && ((addr % n) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
    int n;
    int v;
    n = nbytes(sz);
    v = ((1 << n) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] o;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [63:0] v;
    int bits;
    bits = 8 * nbytes(sz);
    v = ({32'h0, rd} >> (8 * (addr % 4))) & ((64'd1 << bits) - 64'd1);
    if (!uns && v[bits-1]) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic do_access(input logic re, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int waits);
    re_in = re; we_in = we; size_in = sz; unsigned_in = uns; addr_in = addr; wdata_in = wd;
    #1;
    chk("stall_on_request", stall, 1);
    tick();
    for (int w = 0; w <= waits; w++) begin
      chk("wait_mem_req", bus.mem_req, 1);
      chk("wait_mem_we", bus.mem_we, we);
      chk("wait_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
      chk("wait_mem_be", bus.mem_be, m_be(sz, addr));
      if (we) chk("wait_mem_wdata", bus.mem_wdata, m_wdata(sz, wd));
      chk("wait_stall", stall, 1);
      chk("wait_no_valid", rdata_valid, 0);
      if (w == waits) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rd;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    bus.mem_rdata = $urandom;
    if (re) exp_rd = m_load(sz, uns, addr, rd);
    chk("done_mem_req", bus.mem_req, 0);
    chk("done_stall", stall, 0);
    chk("done_rdata_valid", rdata_valid, re);
    chk("done_rdata_out", rdata_out, exp_rd);
    tick();
    chk("after_done_one_txn", bus.mem_req, 0);
    chk("after_done_valid", rdata_valid, 0);
    chk("after_done_rdata_hold", rdata_out, exp_rd);
  endtask

  task automatic bad_access(input logic re, input logic we, input logic [1:0] sz,
                            input logic [31:0] addr);
    re_in = re; we_in = we; size_in = sz; unsigned_in = 1'b0; addr_in = addr;
    #1;
    chk("bad_stall", stall, 0);
    tick();
    chk("bad_misalign_pulse", misalign_err, 1);
    chk("bad_no_req", bus.mem_req, 0);
    re_in = 1'b0; we_in = 1'b0;
    tick();
    chk("bad_misalign_end", misalign_err, 0);
    chk("bad_no_req2", bus.mem_req, 0);
  endtask

  task automatic idle_step();
    re_in = 1'b0; we_in = 1'b0;
    #1;
    chk("idle_stall", stall, 0);
    tick();
    chk("idle_no_misalign", misalign_err, 0);
    chk("idle_no_req", bus.mem_req, 0);
    chk("idle_rdata_hold", rdata_out, exp_rd);
  endtask

  initial begin
    logic        r_re, r_we, r_uns;
    logic [1:0]  r_sz;
    logic [31:0] r_addr;
    int          n;

    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;

    // Reset state, with a legal request present that must not raise stall.
    re_in = 1'b1; size_in = 2'b00; addr_in = 32'h100;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata_out", rdata_out, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_misalign", misalign_err, 0);
    re_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Zero-wait load word.
    do_access(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    chk("lw_result", rdata_out, 32'hDEADBEEF);
    // Signed and unsigned byte loads, back to back.
    do_access(1, 0, 2'b10, 0, 32'h203, 32'h0, 32'h80FF_0000, 0);
    chk("lb_signed", rdata_out, 32'hFFFFFF80);
    do_access(1, 0, 2'b10, 1, 32'h203, 32'h0, 32'h80FF_0000, 1);
    chk("lbu_unsigned", rdata_out, 32'h00000080);
    // Half store with three wait cycles.
    do_access(0, 1, 2'b01, 0, 32'h302, 32'h0000ABCD, 32'h0, 3);
    chk("sh_rdata_unchanged", rdata_out, 32'h00000080);
    // Rejected accesses.
    bad_access(1, 0, 2'b00, 32'h101);
    bad_access(1, 0, 2'b01, 32'h103);
    bad_access(1, 1, 2'b00, 32'h100);
    bad_access(0, 1, 2'b11, 32'h100);

    // An ack with nothing outstanding is ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    idle_step();
    bus.mem_ack = 1'b0;
    chk("stray_ack_no_valid", rdata_valid, 0);

    // Reset while WAIT: request drops at once, late ack ignored.
    re_in = 1'b1; we_in = 1'b0; size_in = 2'b00; addr_in = 32'h400;
    tick();
    chk("pre_rst_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req_drop", bus.mem_req, 0);
    chk("rst_wait_stall", stall, 0);
    re_in = 1'b0;
    exp_rd = 32'h0;
    tick();
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_ack_no_valid", rdata_valid, 0);
    chk("late_ack_no_req", bus.mem_req, 0);
    chk("late_ack_rdata", rdata_out, 32'h0);
    do_access(1, 0, 2'b01, 0, 32'h502, 32'h0, 32'h8001_7FFF, 0);
    chk("post_rst_lh", rdata_out, 32'hFFFF8001);

    // Randomized mix of legal, illegal and idle cycles.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        r_re = 1'($urandom_range(0, 1));
        r_we = ~r_re;
        r_sz = 2'($urandom_range(0, 2));
        n = nbytes(r_sz);
        r_addr = $urandom & ~(32'(n) - 32'd1);
      end else begin
        r_re = 1'($urandom_range(0, 1));
        r_we = 1'($urandom_range(0, 1));
        r_sz = 2'($urandom_range(0, 3));
        r_addr = $urandom;
      end
      r_uns = 1'($urandom_range(0, 1));
      if ((r_re || r_we) && m_legal(r_re, r_we, r_sz, r_addr))
        do_access(r_re, r_we, r_sz, r_uns, r_addr, $urandom, $urandom,
                  int'($urandom_range(0, 3)));
      else if (r_re || r_we)
        bad_access(r_re, r_we, r_sz, r_addr);
      else
        idle_step();
    end
    idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
